// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage (shift-add multiply, restoring divide).
// Optional MULDIV_EARLY_OUT_EN: resolve divide-by-zero, signed overflow and zero multiplies at the start edge.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_func3,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] cnt;
    logic [W-1:0] hi, lo, d, abs_a, abs_b, q, r, fix_res, early_res;
    logic [2:0] f3;
    logic sa, sb, in_sa_en, in_sb_en, in_sa, in_sb, ok, early, go;
    logic [W:0] m_sum, sh, diff;
    logic [2*W-1:0] prod, prod_s;
    assign in_sb_en = (i_func3 == 3'b001) | (i_func3[2] & ~i_func3[0]);
    assign in_sa_en = in_sb_en | (i_func3 == 3'b010);
    assign in_sa = in_sa_en & i_rs1_data[W-1];
    assign in_sb = in_sb_en & i_rs2_data[W-1];
    assign abs_a = in_sa ? -i_rs1_data : i_rs1_data;
    assign abs_b = in_sb ? -i_rs2_data : i_rs2_data;
    assign go = (state == IDLE) & i_start & ~i_flush;
    // {hi,lo} holds product/multiplier for multiply and remainder/quotient for divide
    assign m_sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    assign sh = {hi, lo[W-1]};
    assign diff = sh - {1'b0, d};
    assign ok = ~diff[W];
    assign prod = {hi, lo};
    assign prod_s = (sa ^ sb) ? -prod : prod;
    assign q = (sa ^ sb) ? -lo : lo;
    assign r = sa ? -hi : hi;
    assign fix_res = !f3[2] ? (f3[1:0] == 2'b00 ? prod_s[W-1:0] : prod_s[2*W-1:W])
                   : f3[1] ? r : (d == '0 ? '1 : q);
`ifdef MULDIV_EARLY_OUT_EN
    logic div0, ovf;
    assign div0 = i_rs2_data == '0;
    assign ovf = i_func3[2] & ~i_func3[0] & (i_rs1_data == {1'b1, {(W-1){1'b0}}}) & (&i_rs2_data);
    assign early = i_func3[2] ? (div0 | ovf) : (i_rs1_data == '0 || i_rs2_data == '0);
    assign early_res = !i_func3[2] ? '0 : div0 ? (i_func3[1] ? i_rs1_data : '1)
                     : (i_func3[1] ? '0 : {1'b1, {(W-1){1'b0}}});
`else
    assign early = 1'b0;
    assign early_res = '0;
`endif
    assign o_busy = ~i_rst & (((state == IDLE) & i_start) | (state == CALC) | (state == FIX));
    assign o_done = state == DONE;
    // state register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state; flush returns to IDLE from anywhere
    always_comb begin
        state_nx = state;
        if (i_flush) state_nx = IDLE;
        else begin
            unique case (state)
                IDLE: state_nx = i_start ? (early ? DONE : CALC) : IDLE;
                CALC: state_nx = (&cnt) ? FIX : CALC;
                FIX:  state_nx = DONE;
                DONE: state_nx = IDLE;
            endcase
        end
    end
    // operand latch, one iteration per CALC cycle, result load in FIX
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            {hi, lo, d, f3, sa, sb, cnt} <= '0;
            o_result <= '0;
        end else if (go) begin
            f3 <= i_func3;
            sa <= in_sa;
            sb <= in_sb;
            cnt <= '0;
            hi <= '0;
            d <= i_func3[2] ? abs_b : abs_a;
            lo <= i_func3[2] ? abs_a : abs_b;
            if (early) o_result <= early_res;
        end else if (state == CALC && !i_flush) begin
            cnt <= cnt + 5'd1;
            hi <= f3[2] ? (ok ? diff[W-1:0] : sh[W-1:0]) : m_sum[W:1];
            lo <= f3[2] ? {lo[W-2:0], ok} : {m_sum[0], lo[W-1:1]};
        end else if (state == FIX && !i_flush) begin
            o_result <= fix_res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed bench for ex_muldiv_unit with a queue of expected results.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst, start, flush, busy, done;
    logic [2:0] func3;
    logic [31:0] rs1, rs2, result;
    int errors = 0, checks = 0;
    logic [31:0] exp_q[$];
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif

    always #5 clk = ~clk;

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .i_rst(rst), .i_start(start), .i_func3(func3),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_flush(flush),
        .o_busy(busy), .o_done(done), .o_result(result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int cyc, busy_n;
        @(negedge clk);
        start = 1'b1;
        func3 = f;
        rs1 = a;
        rs2 = b;
        exp_q.push_back(exp);
        #1 check({tag, " busy_start"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_n = 1;
        while (!done && cyc < 60) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy_cycles"}, busy_n, lat);
        check({tag, " result"}, result, exp_q.pop_front());
        check({tag, " busy_in_done"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        func3 = 3'b000;
        rs1 = '0;
        rs2 = '0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
        run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
        run_op("rem_div0", 3'b110, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT);
        run_op("divu_div0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
        @(negedge clk);
        start = 1'b1;
        func3 = 3'b000;
        rs1 = 32'd100;
        rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, 32'hFFFFFFFF);
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);
        @(negedge clk);
        start = 1'b1;
        func3 = 3'b101;
        rs1 = 32'd100;
        rs2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        start = 1'b1;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        run_op("remu_after_rst", 3'b111, 32'd100, 32'd7, 32'd2, 34);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
